iagc_sequencer: RTL and testbench

IAGC_SEQUENCER -- requirements
Module: iagc_sequencer

---
 rtl/iagc_pkg.sv | 39 +++
 rtl/iagc_addr_counter.sv | 22 ++
 rtl/iagc_sequencer.sv | 144 ++++++++++++++
 tb/tb_iagc_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iagc_pkg.sv
// rtl/iagc_pkg.sv - shared IAGC status codes and command opcodes (sequencer and memory)
package iagc_pkg;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_INIT      = 4'd1,
    ST_IDLE      = 4'd2,
    ST_SAMPLE    = 4'd3,
    ST_CMD_PARSE = 4'd4,
    ST_CMD_READ  = 4'd5,
    ST_CMD_ERROR = 4'd6,
    ST_DUMP_REF  = 4'd7,
    ST_DUMP_ERR  = 4'd8,
    ST_CLEAN_MEM = 4'd9,
    ST_SET_MEM   = 4'd10,
    ST_SET_DEC   = 4'd11,
    ST_HALT      = 4'd12
  } iagc_state_t;

  localparam logic [3:0] OP_DUMP_REF  = 4'd1;
  localparam logic [3:0] OP_DUMP_ERR  = 4'd2;
  localparam logic [3:0] OP_CLEAN_MEM = 4'd3;
  localparam logic [3:0] OP_SET_MEM   = 4'd4;
  localparam logic [3:0] OP_SET_DEC   = 4'd5;
  localparam logic [3:0] OP_HALT      = 4'd15;

  function automatic iagc_state_t decode_opcode(input logic [3:0] op);
    case (op)
      OP_DUMP_REF:  return ST_DUMP_REF;
      OP_DUMP_ERR:  return ST_DUMP_ERR;
      OP_CLEAN_MEM: return ST_CLEAN_MEM;
      OP_SET_MEM:   return ST_SET_MEM;
      OP_SET_DEC:   return ST_SET_DEC;
      OP_HALT:      return ST_HALT;
      default:      return ST_CMD_ERROR;
    endcase
  endfunction

endpackage

// File: rtl/iagc_addr_counter.sv
// rtl/iagc_addr_counter.sv - address counter that wraps to zero after reaching limit
module iagc_addr_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc)
      count <= (count == limit) ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/iagc_sequencer.sv
// rtl/iagc_sequencer.sv - IAGC sample/command sequencer driving capture memory addresses
module iagc_sequencer
  import iagc_pkg::*;
#(
  parameter int ADDR_SIZE        = 12,
  parameter int DEF_MEMORY_SIZE  = 4096,
  parameter int IAGC_STATUS_SIZE = 4,
  parameter int CMD_OPCODE_SIZE  = 4,
  parameter int CMD_PARAM_SIZE   = 4
) (
  input  logic                                     i_clock,
  input  logic                                     i_reset,
  input  logic                                     i_sample_valid,
  input  logic                                     i_cmd_valid,
  input  logic [CMD_OPCODE_SIZE+CMD_PARAM_SIZE-1:0] i_cmd,
  input  logic                                     i_clean_end,
  input  logic                                     i_tx_ready,
  output logic [IAGC_STATUS_SIZE-1:0]              o_iagc_status,
  output logic [ADDR_SIZE-1:0]                     o_waddr,
  output logic [ADDR_SIZE-1:0]                     o_raddr,
  output logic [ADDR_SIZE-1:0]                     o_memory_size,
  output logic                                     o_cmd_ready,
  output logic                                     o_cmd_error,
  output logic                                     o_dump_valid,
  output logic                                     o_dump_done,
  output logic                                     o_sample_drop
);

  localparam int CMD_SIZE = CMD_OPCODE_SIZE + CMD_PARAM_SIZE;

  iagc_state_t state, state_nxt;
  logic [CMD_SIZE-1:0]       cmd_q;
  logic [CMD_OPCODE_SIZE-1:0] opcode;
  logic [CMD_PARAM_SIZE-1:0]  param;
  logic [ADDR_SIZE-1:0]      dec, dec_cnt, limit;
  logic                      dump_valid_q;
  logic                      in_dump, last_word, clean_done, dec_hit;
  logic                      cmd_ready, cmd_error, dump_done, sample_drop;

  assign opcode     = cmd_q[CMD_SIZE-1 -: CMD_OPCODE_SIZE];
  assign param      = cmd_q[CMD_PARAM_SIZE-1:0];
  assign limit      = o_memory_size - ADDR_SIZE'(1);
  assign in_dump    = (state == ST_DUMP_REF) || (state == ST_DUMP_ERR);
  assign last_word  = in_dump && dump_valid_q && i_tx_ready && (o_raddr == limit);
  assign clean_done = (state == ST_CLEAN_MEM) && i_clean_end;
  assign dec_hit    = (dec_cnt == dec);

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    cmd_error   = 1'b0;
    dump_done   = 1'b0;
    sample_drop = i_sample_valid && (state != ST_IDLE);
    case (state)
      ST_RESET:     state_nxt = ST_INIT;
      ST_INIT:      state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (i_cmd_valid) begin
          cmd_ready   = 1'b1;
          sample_drop = i_sample_valid;
          state_nxt   = ST_CMD_READ;
        end else if (i_sample_valid && dec_hit) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE:    state_nxt = ST_IDLE;
      ST_CMD_READ:  state_nxt = ST_CMD_PARSE;
      ST_CMD_PARSE: state_nxt = decode_opcode(4'(opcode));
      ST_CMD_ERROR: begin
        cmd_error = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_DUMP_REF, ST_DUMP_ERR: begin
        if (last_word) begin
          dump_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_CLEAN_MEM: if (i_clean_end) state_nxt = ST_IDLE;
      ST_SET_MEM:   state_nxt = ST_IDLE;
      ST_SET_DEC:   state_nxt = ST_IDLE;
      ST_HALT:      state_nxt = ST_HALT;
      default:      state_nxt = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      state <= ST_RESET;
    else
      state <= state_nxt;
  end

  // Dump alternates a one-cycle READ phase (memory latency) with a VALID phase held until accepted.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cmd_q         <= '0;
      dec           <= '0;
      dec_cnt       <= '0;
      o_memory_size <= ADDR_SIZE'(DEF_MEMORY_SIZE - 1);
      dump_valid_q  <= 1'b0;
    end else begin
      dump_valid_q <= in_dump && (!dump_valid_q || !i_tx_ready);
      if (state == ST_CMD_READ)
        cmd_q <= i_cmd;
      if (state == ST_CMD_PARSE && decode_opcode(4'(opcode)) == ST_SET_MEM)
        o_memory_size <= ADDR_SIZE'({param, 8'hFF});
      if (state == ST_SET_DEC) begin
        dec     <= ADDR_SIZE'(param);
        dec_cnt <= '0;
      end else if (clean_done) begin
        dec_cnt <= '0;
      end else if (state == ST_IDLE && i_sample_valid && !i_cmd_valid) begin
        dec_cnt <= dec_hit ? '0 : dec_cnt + ADDR_SIZE'(1);
      end
    end
  end

  iagc_addr_counter #(.WIDTH(ADDR_SIZE)) u_waddr (
    .clk   (i_clock),
    .rst   (i_reset),
    .clear (clean_done || (state == ST_SET_MEM)),
    .inc   (state == ST_SAMPLE),
    .limit (limit),
    .count (o_waddr)
  );

  iagc_addr_counter #(.WIDTH(ADDR_SIZE)) u_raddr (
    .clk   (i_clock),
    .rst   (i_reset),
    .clear (!in_dump),
    .inc   (in_dump && dump_valid_q && i_tx_ready),
    .limit (limit),
    .count (o_raddr)
  );

  assign o_iagc_status = IAGC_STATUS_SIZE'(state);
  assign o_dump_valid  = dump_valid_q;
  assign o_cmd_ready   = cmd_ready && !i_reset;
  assign o_cmd_error   = cmd_error && !i_reset;
  assign o_dump_done   = dump_done && !i_reset;
  assign o_sample_drop = sample_drop && !i_reset;

endmodule

// File: tb/tb_iagc_sequencer.sv
// tb/tb_iagc_sequencer.sv - randomized self-checking bench for iagc_sequencer
module tb_iagc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv = 1'b0, cv = 1'b0, ce = 1'b0, txr = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [3:0]  status;
  logic [11:0] waddr, raddr, msize;
  logic        cmd_ready, cmd_error, dump_valid, dump_done, sample_drop;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffer depth, write pointer and decimation phase as plain integers
  int m_waddr, m_size, m_dec, m_cnt;

  iagc_sequencer dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_sample_valid (sv),
    .i_cmd_valid    (cv),
    .i_cmd          (cmd),
    .i_clean_end    (ce),
    .i_tx_ready     (txr),
    .o_iagc_status  (status),
    .o_waddr        (waddr),
    .o_raddr        (raddr),
    .o_memory_size  (msize),
    .o_cmd_ready    (cmd_ready),
    .o_cmd_error    (cmd_error),
    .o_dump_valid   (dump_valid),
    .o_dump_done    (dump_done),
    .o_sample_drop  (sample_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int target_of(input int op);
    case (op)
      1: return 7;
      2: return 8;
      3: return 9;
      4: return 10;
      5: return 11;
      15: return 12;
      default: return 6;
    endcase
  endfunction

  task automatic do_reset;
    rst = 1'b1; sv = 1'b0; cv = 1'b0; ce = 1'b0; txr = 1'b0;
    tick; tick;
    check("reset_status", status, 0);
    check("reset_waddr", waddr, 0);
    check("reset_raddr", raddr, 0);
    check("reset_msize", msize, 4095);
    check("reset_dump_valid", dump_valid, 0);
    rst = 1'b0;
    #1;
    check("release_status", status, 0);
    tick;
    check("init_status", status, 1);
    tick;
    check("idle_status", status, 2);
    m_waddr = 0; m_size = 4095; m_dec = 0; m_cnt = 0;
  endtask

  task automatic strobe(output int sampled);
    sv = 1'b1;
    #1;
    check("idle_strobe_drop", sample_drop, 0);
    tick;
    sv = 1'b0;
    if (m_cnt == m_dec) begin
      m_cnt = 0;
      sampled = 1;
      check("sample_state", status, 3);
      check("sample_waddr_stable", waddr, m_waddr);
      m_waddr = (m_waddr + 1) % m_size;
      tick;
    end else begin
      m_cnt++;
      sampled = 0;
    end
    check("post_strobe_status", status, 2);
    check("waddr", waddr, m_waddr);
  endtask

  task automatic issue(input int op, input int par, input bit collide, input bit poke);
    cmd = 8'(op * 16 + par);
    cv = 1'b1;
    sv = collide;
    #1;
    check("cmd_ready", cmd_ready, 1);
    check("collide_drop", sample_drop, int'(collide));
    tick;
    cv = 1'b0;
    check("cmd_read", status, 5);
    sv = poke;
    #1;
    check("busy_drop", sample_drop, int'(poke));
    tick;
    sv = 1'b0;
    check("cmd_parse", status, 4);
    tick;
    check("cmd_target", status, target_of(op));
  endtask

  task automatic run_dump(input int gap);
    int handshakes = 0;
    int dones = 0;
    int waited, d;
    check("dump_first_read", dump_valid, 0);
    check("dump_start_raddr", raddr, 0);
    for (int k = 0; k < m_size; k++) begin
      waited = 0;
      while (!dump_valid && waited < 8) begin
        tick;
        waited++;
      end
      check("dump_valid_seen", dump_valid, 1);
      if (!dump_valid) break;
      check("dump_raddr", raddr, k);
      d = (gap < 0) ? $urandom_range(0, 3) : gap;
      repeat (d) begin
        tick;
        check("dump_hold", dump_valid, 1);
      end
      txr = 1'b1;
      #1;
      check("dump_done_pulse", dump_done, int'(k == m_size - 1));
      handshakes++;
      if (dump_done) dones++;
      tick;
      txr = 1'b0;
      if (k != m_size - 1) check("dump_read_phase", dump_valid, 0);
    end
    check("dump_handshakes", handshakes, m_size);
    check("dump_done_count", dones, 1);
    check("dump_end_status", status, 2);
    check("dump_end_raddr", raddr, 0);
  endtask

  task automatic do_cmd(input int op, input int par, input int gap, input bit collide, input bit poke);
    issue(op, par, collide, poke);
    case (target_of(op))
      6: begin
        check("cmd_error_pulse", cmd_error, 1);
        tick;
        check("cmd_error_clear", cmd_error, 0);
        check("error_to_idle", status, 2);
      end
      7, 8: run_dump(gap);
      9: begin
        repeat ($urandom_range(0, 4)) begin
          tick;
          check("clean_hold", status, 9);
        end
        ce = 1'b1;
        tick;
        ce = 1'b0;
        m_waddr = 0; m_cnt = 0;
        check("clean_to_idle", status, 2);
        check("clean_waddr", waddr, 0);
      end
      10: begin
        m_size = par * 256 + 255;
        m_waddr = 0;
        check("set_mem_size", msize, m_size);
        tick;
        check("set_mem_to_idle", status, 2);
        check("set_mem_waddr", waddr, 0);
      end
      11: begin
        m_dec = par; m_cnt = 0;
        tick;
        check("set_dec_to_idle", status, 2);
      end
      default: begin
        for (int i = 0; i < 3; i++) begin
          cmd = 8'h20; cv = 1'b1; sv = 1'b1;
          #1;
          check("halt_cmd_ready", cmd_ready, 0);
          check("halt_drop", sample_drop, 1);
          tick;
          check("halt_stays", status, 12);
        end
        cv = 1'b0; sv = 1'b0;
      end
    endcase
  endtask

  initial begin
    int s, samples, r, op;
    do_reset;

    do_cmd(5, 2, 0, 0, 0);
    samples = 0;
    repeat (6) begin
      strobe(s);
      samples += s;
    end
    check("dec2_samples", samples, 2);
    check("dec2_waddr", waddr, 2);

    do_cmd(4, 0, 0, 0, 0);
    check("size255", msize, 255);
    do_cmd(5, 0, 0, 0, 0);
    repeat (257) strobe(s);
    check("wrap_final_waddr", waddr, 2);

    do_cmd(1, 0, 3, 0, 0);
    do_cmd(2, 0, -1, 0, 1);

    do_cmd(7, 0, 0, 1, 0);
    check("collide_then_idle", status, 2);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) strobe(s);
      else if (r == 6) do_cmd(5, $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r == 7) begin
        op = $urandom_range(5, 14);
        if (op == 5) op = 0;
        do_cmd(op, $urandom_range(0, 15), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      else if (r == 8) do_cmd(4, $urandom_range(0, 1), 0, 0, 1'($urandom_range(0, 1)));
      else do_cmd(3, 0, 0, 1'($urandom_range(0, 1)), 0);
    end

    do_cmd(15, 0, 0, 0, 0);
    do_reset;

    issue(3, 0, 0, 0);
    tick; tick;
    #3;
    rst = 1'b1;
    #1;
    check("abort_clean_status", status, 0);
    do_reset;
    check("abort_clean_recovers", status, 2);

    issue(1, 0, 0, 0);
    tick;
    txr = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("abort_dump_status", status, 0);
    check("abort_dump_done", dump_done, 0);
    check("abort_dump_valid", dump_valid, 0);
    check("abort_dump_raddr", raddr, 0);
    do_reset;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
